// File: rtl/ct_f_spsram_init_wrap.sv
// Sliced FPGA single-port SRAM wrapper with optional output register
// and a hardware clear engine that sweeps INIT_VAL into every entry.
module ct_f_spsram_init_wrap #(
    parameter int                   ADDR_WIDTH = 8,
    parameter int                   DATA_WIDTH = 52,
    parameter int                   WRAP_SIZE  = 26,
    parameter bit                   INIT_EN    = 1'b1,
    parameter logic [WRAP_SIZE-1:0] INIT_VAL   = '0,
    parameter bit                   OUT_REG    = 1'b0
) (
    input  logic                  CLK,
    input  logic                  cpurst_b,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic                  CEN,
    input  logic                  GWEN,
    input  logic [DATA_WIDTH-1:0] WEN,
    input  logic [DATA_WIDTH-1:0] D,
    input  logic                  INIT_REQ,
    output logic [DATA_WIDTH-1:0] Q,
    output logic                  INIT_BUSY
);

    localparam int DEPTH     = 2 ** ADDR_WIDTH;
    localparam int SLICE_NUM = DATA_WIDTH / WRAP_SIZE;

    if (DATA_WIDTH % WRAP_SIZE != 0) begin : g_width_chk
        $error("DATA_WIDTH must be a multiple of WRAP_SIZE");
    end

    typedef enum logic {
        ST_READY = 1'b0,
        ST_INIT  = 1'b1
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic [ADDR_WIDTH-1:0] cnt_d;
    logic [ADDR_WIDTH-1:0] addr_hold;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  busy;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  rd_vld;
    logic                  rd_load;
    logic [DATA_WIDTH-1:0] rd_all;
    logic                  unused_wen;

    always_ff @(posedge CLK or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q <= INIT_EN ? ST_INIT : ST_READY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) state_d = ST_READY;
            end
            ST_READY: begin
                if (INIT_REQ) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            end
            default: ;
        endcase
    end

    assign busy      = (state_q == ST_INIT);
    assign INIT_BUSY = busy;
    assign rd_acc    = !busy && !CEN && GWEN;
    assign wr_acc    = !busy && !CEN && !GWEN;
    assign ram_addr  = busy ? cnt_q : (CEN ? addr_hold : A);
    // idle cycles keep re-reading the held entry once any read has happened
    assign rd_load   = busy || rd_acc || (CEN && rd_vld);
    assign unused_wen = ^WEN;

    always_ff @(posedge CLK or negedge cpurst_b) begin
        if (!cpurst_b) begin
            addr_hold <= '0;
            rd_vld    <= 1'b0;
        end else begin
            if (busy) addr_hold <= '0;
            else if (!CEN) addr_hold <= A;
            if (busy || rd_acc) rd_vld <= 1'b1;
        end
    end

    for (genvar k = 0; k < SLICE_NUM; k++) begin : g_slice
        logic [WRAP_SIZE-1:0] mem [DEPTH];
        logic [WRAP_SIZE-1:0] rd_s;
        logic [WRAP_SIZE-1:0] wd;
        logic                 we;

        assign we = busy || (wr_acc && !WEN[k*WRAP_SIZE+WRAP_SIZE-1]);
        assign wd = busy ? INIT_VAL : D[k*WRAP_SIZE +: WRAP_SIZE];

        always_ff @(posedge CLK) begin
            if (we) mem[ram_addr] <= wd;
        end

        always_ff @(posedge CLK or negedge cpurst_b) begin
            if (!cpurst_b) rd_s <= '0;
            else if (rd_load) rd_s <= busy ? INIT_VAL : mem[ram_addr];
        end

        assign rd_all[k*WRAP_SIZE +: WRAP_SIZE] = rd_s;
    end

    if (OUT_REG) begin : g_oreg
        logic [DATA_WIDTH-1:0] q_pipe;
        always_ff @(posedge CLK or negedge cpurst_b) begin
            if (!cpurst_b) q_pipe <= '0;
            else q_pipe <= rd_all;
        end
        assign Q = busy ? '0 : q_pipe;
    end else begin : g_nreg
        assign Q = busy ? '0 : rd_all;
    end

endmodule

// File: tb/tb_ct_f_spsram_init_wrap.sv
// Scoreboard bench: default instance plus OUT_REG=1/INIT_EN=0 instance,
// both driven by one stimulus stream and checked against an array model.
module tb_ct_f_spsram_init_wrap;

    logic        CLK = 1'b0;
    logic        cpurst_b;
    logic [7:0]  A;
    logic        CEN;
    logic        GWEN;
    logic [51:0] WEN;
    logic [51:0] D;
    logic        INIT_REQ;
    logic [51:0] q0, q1;
    logic        b0, b1;

    always #5 CLK = ~CLK;

    ct_f_spsram_init_wrap dut0 (
        .CLK(CLK), .cpurst_b(cpurst_b), .A(A), .CEN(CEN), .GWEN(GWEN),
        .WEN(WEN), .D(D), .INIT_REQ(INIT_REQ), .Q(q0), .INIT_BUSY(b0)
    );

    ct_f_spsram_init_wrap #(.INIT_EN(1'b0), .OUT_REG(1'b1)) dut1 (
        .CLK(CLK), .cpurst_b(cpurst_b), .A(A), .CEN(CEN), .GWEN(GWEN),
        .WEN(WEN), .D(D), .INIT_REQ(INIT_REQ), .Q(q1), .INIT_BUSY(b1)
    );

    typedef struct {
        int          due;
        bit          is_rd;
        logic [51:0] exp;
        logic [51:0] msk;
        bit          busy;
        bit          qz;
    } rec_t;

    rec_t sb0[$];
    rec_t sb1[$];
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;

    // reference model: contents plus a known-bit mask per entry
    logic [51:0] mem [2][256];
    logic [51:0] msk [2][256];
    bit          busy_m [2];
    int          left_m [2];
    logic [7:0]  hold_m [2];
    bit          hv_m [2];
    bit          p1_v;
    logic [51:0] p1_ex, p1_mk;

    function automatic void check(input int k, input rec_t r);
        logic [51:0] q;
        logic        b;
        q = (k == 0) ? q0 : q1;
        b = (k == 0) ? b0 : b1;
        checks++;
        if (r.is_rd) begin
            if ((q & r.msk) === (r.exp & r.msk)) passes++;
            else $display("FAIL read dut%0d cyc %0d: Q=%h expected %h mask %h",
                          k, cyc, q, r.exp, r.msk);
        end else begin
            if (b === r.busy && (!r.qz || q === 52'h0)) passes++;
            else $display("FAIL busy dut%0d cyc %0d: INIT_BUSY=%b Q=%h expected busy %b qzero %b",
                          k, cyc, b, q, r.busy, r.qz);
        end
    endfunction

    initial begin
        rec_t r;
        forever begin
            @(posedge CLK);
            cyc++;
            #1;
            while (sb0.size() > 0 && sb0[0].due <= cyc) begin
                r = sb0.pop_front();
                check(0, r);
            end
            while (sb1.size() > 0 && sb1[0].due <= cyc) begin
                r = sb1.pop_front();
                check(1, r);
            end
        end
    end

    function automatic void push(input int k, input rec_t r);
        if (k == 0) sb0.push_back(r);
        else sb1.push_back(r);
    endfunction

    task automatic step(input bit rst, input bit cen, input bit gwen,
                        input logic [51:0] wen, input logic [7:0] a,
                        input logic [51:0] d, input bit req);
        int          e;
        bit          rd;
        logic [51:0] ex, mk;
        rec_t        r;
        e = cyc + 1;
        cpurst_b = !rst;
        CEN = cen; GWEN = gwen; WEN = wen; A = a; D = d; INIT_REQ = req;
        for (int k = 0; k < 2; k++) begin
            rd = 0; ex = '0; mk = '0;
            if (rst) begin
                busy_m[k] = (k == 0);
                left_m[k] = 256;
                hold_m[k] = '0;
                hv_m[k] = 0;
                for (int i = 0; i < 256; i++) begin
                    mem[k][i] = '0;
                    msk[k][i] = (k == 0) ? {52{1'b1}} : '0;
                end
            end else if (busy_m[k]) begin
                left_m[k]--;
                if (left_m[k] == 0) begin
                    busy_m[k] = 0;
                    hold_m[k] = '0;
                    hv_m[k] = 1;
                end
            end else begin
                if (!cen) begin
                    hold_m[k] = a;
                    if (gwen) begin
                        rd = 1;
                        hv_m[k] = 1;
                    end else begin
                        for (int s = 0; s < 2; s++) begin
                            if (!wen[s*26+25]) begin
                                mem[k][a][s*26 +: 26] = d[s*26 +: 26];
                                msk[k][a][s*26 +: 26] = '1;
                            end
                        end
                    end
                end else if (hv_m[k]) begin
                    rd = 1;
                end
                if (rd) begin
                    ex = mem[k][hold_m[k]];
                    mk = msk[k][hold_m[k]];
                end
                if (req) begin
                    busy_m[k] = 1;
                    left_m[k] = 256;
                    hold_m[k] = '0;
                    hv_m[k] = 1;
                    for (int i = 0; i < 256; i++) begin
                        mem[k][i] = '0;
                        msk[k][i] = {52{1'b1}};
                    end
                end
            end
            r = '{due: e, is_rd: 0, exp: '0, msk: '0, busy: busy_m[k],
                  qz: busy_m[k] || rst};
            push(k, r);
            if (k == 0) begin
                if (rd && !busy_m[0] && mk != '0) begin
                    r = '{due: e, is_rd: 1, exp: ex, msk: mk, busy: 0, qz: 0};
                    push(0, r);
                end
            end else begin
                if (p1_v && !busy_m[1] && !rst) begin
                    r = '{due: e, is_rd: 1, exp: p1_ex, msk: p1_mk, busy: 0, qz: 0};
                    push(1, r);
                end
                p1_v = rd && !busy_m[1] && mk != '0 && !rst;
                p1_ex = ex;
                p1_mk = mk;
            end
        end
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 1, '1, 8'h00, '0, 0);
    endtask

    task automatic wr(input logic [7:0] a, input logic [51:0] d, input logic [51:0] wen);
        step(0, 0, 0, wen, a, d, 0);
    endtask

    task automatic rdq(input logic [7:0] a);
        step(0, 0, 1, '1, a, '0, 0);
    endtask

    initial begin
        logic [51:0] rw, rdat;
        int          op;
        p1_v = 0;
        cpurst_b = 1'b0;
        CEN = 1'b1; GWEN = 1'b1; WEN = '1; D = '0; A = '0; INIT_REQ = 1'b0;
        @(negedge CLK);
        for (int i = 0; i < 3; i++) step(1, 1, 1, '1, 8'h00, '0, 0);
        idle(260);
        rdq(8'h00); rdq(8'h80); rdq(8'hFF); idle(2);
        wr(8'h3C, 52'hA_BCDE_F012_3456, '0);
        rdq(8'h3C);
        idle(5);
        wr(8'h10, {52{1'b1}}, '0);
        rw = {52{1'b1}};
        rw[25] = 1'b0;
        wr(8'h10, '0, rw);
        rdq(8'h10); idle(2);
        step(0, 0, 0, '0, 8'h05, 52'h1234, 1);
        for (int i = 0; i < 5; i++) wr(8'h05, 52'hFFFF, '0);
        idle(255);
        rdq(8'h05); rdq(8'h10); idle(2);
        step(0, 1, 1, '1, 8'h00, '0, 1);
        idle(100);
        for (int i = 0; i < 3; i++) step(1, 1, 1, '1, 8'h00, '0, 0);
        idle(260);
        wr(8'hFF, 52'h5_5AA5_0FF0_C33C, '0);
        rdq(8'hFF);
        idle(3);
        for (int i = 0; i < 1500; i++) begin
            op = $urandom_range(0, 99);
            rdat = {$urandom, $urandom};
            rw = {$urandom, $urandom};
            if (op < 40) rdq(8'($urandom_range(0, 15)));
            else if (op < 75) wr(8'($urandom_range(0, 15)), rdat, rw);
            else if (op < 99) idle(1);
            else step(0, 1, 1, '1, 8'h00, '0, 1);
        end
        idle(6);
        if (sb0.size() + sb1.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0",
                     sb0.size() + sb1.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
